// File: rtl/sigma_delta_osc_bank.sv
// Bank of NCH magic-circle sine oscillators, each driving a first-order sigma-delta modulator.
// Define SD_DITHER_EN to add shared LFSR dither to the quantiser decision.
module sigma_delta_osc_bank #(
   parameter int NCH      = 2,
   parameter int BITWIDTH = 40,
   parameter int FRAC     = 32,
   parameter int OSR      = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [3:0]          cfg_chan,
   input  logic                cfg_en,
   input  logic [FRAC-1:0]     cfg_k,
   input  logic [BITWIDTH-2:0] cfg_amp,
   output logic                sample_tick,
   output logic [NCH-1:0]      sd_out
);
   localparam int AW = BITWIDTH + 2;
   localparam int PW = 2 * BITWIDTH;
   localparam int CW = $clog2(OSR);
   localparam logic signed [AW-1:0] FS = AW'(1) << (BITWIDTH - 2);

   typedef enum logic {S_IDLE, S_LOAD} cfg_state_t;

   cfg_state_t                 state;
   logic [3:0]                 cap_chan;
   logic                       cap_en;
   logic [FRAC-1:0]            cap_k;
   logic [BITWIDTH-2:0]        cap_amp;
   logic [CW-1:0]              cnt;
   logic                       strobe;
   logic [NCH-1:0]             en_q;
   logic [FRAC-1:0]            k_q     [NCH];
   logic signed [BITWIDTH-1:0] x1_q    [NCH];
   logic signed [BITWIDTH-1:0] x2_q    [NCH];
   logic signed [BITWIDTH-1:0] x1_nxt  [NCH];
   logic signed [BITWIDTH-1:0] x2_nxt  [NCH];
   logic signed [AW-1:0]       acc_q   [NCH];
   logic signed [AW-1:0]       acc_nxt [NCH];
   logic signed [AW-1:0]       dec_sum [NCH];
   logic [NCH-1:0]             q;
   logic [NCH-1:0]             load_hit;
   logic signed [AW-1:0]       dither;

   assign strobe = (cnt == CW'(OSR - 1));

   // (k * x) >>> FRAC with k treated as a non-negative Q0.FRAC fraction.
   function automatic logic signed [BITWIDTH-1:0] kmul(input logic [FRAC-1:0] k,
                                                       input logic signed [BITWIDTH-1:0] x);
      logic signed [PW-1:0] kk;
      logic signed [PW-1:0] xx;
      logic signed [PW-1:0] p;
      kk = $signed({{(PW-FRAC){1'b0}}, k});
      xx = $signed({{BITWIDTH{x[BITWIDTH-1]}}, x});
      p  = kk * xx;
      return BITWIDTH'(p >>> FRAC);
   endfunction

`ifdef SD_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= 16'hACE1;
      else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign dither = $signed({{(AW-8){lfsr[7]}}, lfsr[7:0]}) <<< (BITWIDTH - 10);
`else
   assign dither = '0;
`endif

   // NOTE: every variable in this block is assigned on every pass, so no latch is inferred.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         load_hit[c] = (state == S_LOAD) && (cap_chan == 4'(c));
         x1_nxt[c]   = x1_q[c] - kmul(k_q[c], x2_q[c]);
         x2_nxt[c]   = x2_q[c] + kmul(k_q[c], x1_nxt[c]);
         dec_sum[c]  = acc_q[c] + dither;
         q[c]        = ~dec_sum[c][AW-1];
         acc_nxt[c]  = acc_q[c] + $signed({{2{x1_q[c][BITWIDTH-1]}}, x1_q[c]}) - (q[c] ? FS : -FS);
      end
   end

   // NOTE: non-blocking assignments here so every channel updates from the pre-edge state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cfg_ready   <= 1'b1;
         cap_chan    <= '0;
         cap_en      <= 1'b0;
         cap_k       <= '0;
         cap_amp     <= '0;
         cnt         <= '0;
         sample_tick <= 1'b0;
         sd_out      <= '0;
         en_q        <= '0;
         // NOTE: per-channel state is a few flops, not a RAM, so it takes the reset like everything else.
         for (int c = 0; c < NCH; c++) begin
            k_q[c]   <= '0;
            x1_q[c]  <= '0;
            x2_q[c]  <= '0;
            acc_q[c] <= '0;
         end
      end else begin
         cnt         <= strobe ? '0 : cnt + CW'(1);
         sample_tick <= strobe;
         sd_out      <= q;

         case (state)
            S_IDLE: if (cfg_valid) begin
               cap_chan  <= cfg_chan;
               cap_en    <= cfg_en;
               cap_k     <= cfg_k;
               cap_amp   <= cfg_amp;
               state     <= S_LOAD;
               cfg_ready <= 1'b0;
            end
            S_LOAD: begin
               state     <= S_IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               cfg_ready <= 1'b1;
            end
         endcase

         // A load takes priority over both the modulator and an oscillator step on the same edge.
         for (int c = 0; c < NCH; c++) begin
            if (load_hit[c]) begin
               en_q[c]  <= cap_en;
               k_q[c]   <= cap_k;
               x1_q[c]  <= cap_en ? $signed({1'b0, cap_amp}) : '0;
               x2_q[c]  <= '0;
               acc_q[c] <= '0;
            end else begin
               acc_q[c] <= acc_nxt[c];
               if (strobe && en_q[c]) begin
                  x1_q[c] <= x1_nxt[c];
                  x2_q[c] <= x2_nxt[c];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sigma_delta_osc_bank.sv
// Randomised self-checking bench for sigma_delta_osc_bank against a cycle-level arithmetic model.
// Dither expectations follow SD_DITHER_EN when it is defined for both files.
module tb_sigma_delta_osc_bank;
   localparam int NCH  = 2;
   localparam int BW   = 40;
   localparam int FRAC = 32;
   localparam int OSR  = 4;
   localparam longint FS_M = longint'(1) << (BW - 2);

   logic            clk;
   logic            reset_n;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [3:0]      cfg_chan;
   logic            cfg_en;
   logic [FRAC-1:0] cfg_k;
   logic [BW-2:0]   cfg_amp;
   logic            sample_tick;
   logic [NCH-1:0]  sd_out;

   sigma_delta_osc_bank #(.NCH(NCH), .BITWIDTH(BW), .FRAC(FRAC), .OSR(OSR)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_chan    (cfg_chan),
      .cfg_en      (cfg_en),
      .cfg_k       (cfg_k),
      .cfg_amp     (cfg_amp),
      .sample_tick (sample_tick),
      .sd_out      (sd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic signed [127:0] got,
                        input logic signed [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic, one call per rising edge.
   longint         m_x1 [NCH];
   longint         m_x2 [NCH];
   longint         m_acc[NCH];
   longint         m_k  [NCH];
   bit             m_en [NCH];
   int             m_edges;
   bit             m_busy;
   int             p_chan;
   bit             p_en;
   longint         p_k, p_amp;
   longint         m_d;
   bit             m_strobe;
   logic [15:0]    m_lfsr;
   logic [NCH-1:0] e_sd;
   logic           e_tick, e_ready;

   function automatic longint kscale(input longint k, input longint x);
      logic signed [127:0] prod;
      prod = 128'(k) * 128'(x);
      return longint'(prod >>> FRAC);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_x1[c] = 0; m_x2[c] = 0; m_acc[c] = 0; m_k[c] = 0; m_en[c] = 0;
         end
         m_edges = 0; m_busy = 0; m_lfsr = 16'hACE1;
         e_sd = '0; e_tick = 0; e_ready = 1;
      end else begin
         m_edges++;
         m_strobe = (m_edges % OSR) == 0;
         m_d = 0;
`ifdef SD_DITHER_EN
         m_d = longint'($signed(m_lfsr[7:0])) * (longint'(1) << (BW - 10));
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
         for (int c = 0; c < NCH; c++) begin
            e_sd[c] = (m_acc[c] + m_d) >= 0;
            m_acc[c] = m_acc[c] + m_x1[c] - (e_sd[c] ? FS_M : -FS_M);
            if (m_busy && p_chan == c) begin
               m_en[c] = p_en; m_k[c] = p_k;
               m_x1[c] = p_en ? p_amp : 0; m_x2[c] = 0; m_acc[c] = 0;
            end else if (m_strobe && m_en[c]) begin
               m_x1[c] = m_x1[c] - kscale(m_k[c], m_x2[c]);
               m_x2[c] = m_x2[c] + kscale(m_k[c], m_x1[c]);
            end
         end
         e_tick = m_strobe;
         if (m_busy) m_busy = 0;
         else if (cfg_valid) begin
            m_busy = 1; p_chan = int'(cfg_chan); p_en = cfg_en;
            p_k = longint'(cfg_k); p_amp = longint'(cfg_amp);
         end
         e_ready = !m_busy;
      end
   end

   bit mon_on = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         check("mon_sd_out", sd_out, e_sd);
         check("mon_sample_tick", sample_tick, e_tick);
         check("mon_cfg_ready", cfg_ready, e_ready);
      end
   end

   function automatic longint rand_amp();
      return (longint'($urandom) << 5) | longint'($urandom_range(0, 31));
   endfunction

   task automatic cfg_send(input int ch, input bit en, input longint k, input longint amp);
      int guard = 0;
      cfg_valid = 1'b1;
      cfg_chan  = 4'(ch);
      cfg_en    = en;
      cfg_k     = k[FRAC-1:0];
      cfg_amp   = amp[BW-2:0];
      while (!cfg_ready && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      check("cfg_ready_wait", cfg_ready, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_tick && n < 4 * OSR);
      check("tick_wait", sample_tick, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int     first_tick, ones0, ones1, reps;
   logic   prev;
   longint a, k0, k1, amp_c;

   initial begin
      reset_n = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_en = 1'b0; cfg_k = '0; cfg_amp = '0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sd_out", sd_out, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_sample_tick", sample_tick, 0);
      mon_on  = 1;
      reset_n = 1'b1;

      // Released between edges: the first strobe edge is the OSR-th, tick seen right after it.
      first_tick = 0;
      for (int i = 1; i <= 4 * OSR; i++) begin
         @(negedge clk);
         if (i <= 4) check("post_rst_alt", sd_out, (i % 2 == 1) ? {NCH{1'b1}} : {NCH{1'b0}});
         check("tick_period", sample_tick, (i % OSR) == 0);
         if (sample_tick && first_tick == 0) first_tick = i;
      end
      check("tick_first_edge", first_tick, OSR);

      cfg_send(0, 1, 0, FS_M / 2);
      @(negedge clk);
      ones0 = 0; ones1 = 0;
      repeat (400) begin
         @(negedge clk);
         ones0 += int'(sd_out[0]);
         ones1 += int'(sd_out[1]);
      end
      check("dc_ch0_ones_300pm1", (ones0 >= 299 && ones0 <= 301), 1);
      check("dc_ch1_ones", ones1, 200);

      a = longint'(1) << 36;
      wait_tick();
      cfg_send(0, 1, longint'(1) << 31, a);
      wait_tick();
      check("osc1_x1", dut.x1_q[0], a);
      check("osc1_x2", dut.x2_q[0], a / 2);
      wait_tick();
      check("osc2_x1", dut.x1_q[0], 3 * a / 4);
      check("osc2_x2", dut.x2_q[0], 7 * a / 8);

      k0 = longint'($urandom) | 1;
      k1 = longint'($urandom) | 2;
      if (k1 == k0) k1 = k0 ^ 4;
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1;
         cfg_chan  = (i < 2) ? 4'd0 : 4'd1;
         cfg_en    = 1'b1;
         cfg_k     = (i < 2) ? k0[FRAC-1:0] : k1[FRAC-1:0];
         cfg_amp   = rand_amp();
         check("hs_ready", cfg_ready, (i % 2) == 0);
         if (i == 2) begin
            check("hs_ch0_first", dut.k_q[0], k0);
            check("hs_ch1_pending", dut.k_q[1], 0);
         end
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      check("hs_ch0_kept", dut.k_q[0], k0);
      check("hs_ch1_loaded", dut.k_q[1], k1);

      cfg_send(5, 0, longint'($urandom), rand_amp());
      repeat (2) @(negedge clk);
      check("oor_k0", dut.k_q[0], k0);
      check("oor_k1", dut.k_q[1], k1);
      check("oor_en", dut.en_q, 2'b11);

      wait_tick();
      repeat (2) @(negedge clk);
      amp_c = rand_amp();
      cfg_send(1, 1, k1, amp_c);
      @(negedge clk);
      check("col_tick", sample_tick, 1);
      check("col_x1", dut.x1_q[1], amp_c);
      check("col_x2", dut.x2_q[1], 0);
      check("col_acc", dut.acc_q[1], 0);

      repeat (60) begin
         cfg_send($urandom_range(0, 3), $urandom_range(0, 3) != 0, longint'($urandom), rand_amp());
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end

      cfg_send(1, 1, longint'($urandom) | 1, rand_amp());
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("abort_en1", dut.en_q[1], 0);
      check("abort_k1", dut.k_q[1], 0);
      check("abort_x1", dut.x1_q[1], 0);
      reset_n = 1'b1;

      cfg_send(0, 1, 0, 0);
      @(negedge clk);
      @(negedge clk);
      prev = sd_out[0];
      ones0 = 0; reps = 0;
      repeat (1024) begin
         @(negedge clk);
         ones0 += int'(sd_out[0]);
         if (sd_out[0] == prev) reps++;
         prev = sd_out[0];
      end
`ifdef SD_DITHER_EN
      check("dither_not_alternating", reps > 0, 1);
      check("dither_ones_512pm32", (ones0 >= 480 && ones0 <= 544), 1);
`else
      check("nodither_repeats", reps, 0);
      check("nodither_ones", ones0, 512);
`endif

      mon_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
